// File: rtl/mips_prog_loader.sv
// Program loader and run controller for the single-cycle MIPS core: streams
// 32-bit words into byte-wide instruction memory (MSB first), then runs the core.
module mips_prog_loader #(
  parameter int          IMEM_ADDR_W = 8,
  parameter int          CYC_W       = 16,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [IMEM_ADDR_W-2:0] prog_len,
  input  logic [CYC_W-1:0]       run_cycles,
  input  logic                   s_valid,
  input  logic [31:0]            s_data,
  output logic                   s_ready,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [7:0]             imem_wdata,
  output logic                   core_reset,
  input  logic [31:0]            core_pc,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [CYC_W-1:0]       cycle_count,
  output logic [31:0]            halt_pc
);

  localparam int LEN_W = IMEM_ADDR_W - 1;
  localparam int EXT_W = IMEM_ADDR_W + 2;
  localparam int CW1   = CYC_W + 1;
  localparam logic [EXT_W-1:0] CAPACITY = EXT_W'(1) << IMEM_ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {ST_NONE, ST_PASS_END, ST_TIMEOUT, ST_LEN_ERR} status_e;

  state_e                 state;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       word_idx;
  logic [1:0]             byte_idx;
  logic [23:0]            word_q;
  logic [IMEM_ADDR_W-1:0] word_addr;
  logic [CYC_W-1:0]       run_q;
  logic [31:0]            end_pc;

  // End of the requested image, computed wide enough that it cannot wrap.
  logic [EXT_W-1:0] req_top;
  logic             len_bad;
  logic             budget_hit;

  assign req_top    = EXT_W'(BASE_ADDR) + {1'b0, prog_len, 2'b00};
  assign len_bad    = (prog_len == '0) || (req_top > CAPACITY);
  assign budget_hit = (run_q != '0) &&
                      (({1'b0, cycle_count} + CW1'(1)) == {1'b0, run_q});

  // NOTE: all state lives in one clocked block and uses non-blocking
  // assignments, so every output is a register and reads see last-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are reset too; with no memories here the
      // cost is nil and simulation never starts from X.
      state       <= S_IDLE;
      s_ready     <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= ST_NONE;
      cycle_count <= '0;
      halt_pc     <= '0;
      len_q       <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      word_q      <= '0;
      word_addr   <= '0;
      run_q       <= '0;
      end_pc      <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q       <= prog_len;
            run_q       <= run_cycles;
            end_pc      <= 32'(BASE_ADDR) + 32'({prog_len, 2'b00});
            cycle_count <= '0;
            status      <= ST_NONE;
            word_idx    <= '0;
            word_addr   <= IMEM_ADDR_W'(BASE_ADDR);
            done        <= 1'b0;
            if (len_bad) begin
              state   <= S_DONE;
              done    <= 1'b1;
              status  <= ST_LEN_ERR;
              halt_pc <= '0;
            end else begin
              state   <= S_LOAD;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (s_valid && s_ready) begin
            state      <= S_WRITE;
            s_ready    <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= word_addr;
            imem_wdata <= s_data[31:24];
            word_q     <= s_data[23:0];
            byte_idx   <= 2'd0;
          end
        end

        S_WRITE: begin
          if (byte_idx == 2'd3) begin
            imem_we   <= 1'b0;
            word_idx  <= word_idx + LEN_W'(1);
            word_addr <= word_addr + IMEM_ADDR_W'(4);
            if (word_idx + LEN_W'(1) == len_q) begin
              state      <= S_RUN;
              core_reset <= 1'b0;
            end else begin
              state   <= S_LOAD;
              s_ready <= 1'b1;
            end
          end else begin
            // Remaining bytes shift up out of word_q, MSB first.
            byte_idx   <= byte_idx + 2'd1;
            imem_addr  <= imem_addr + IMEM_ADDR_W'(1);
            imem_wdata <= word_q[23:16];
            word_q     <= {word_q[15:0], 8'h00};
          end
        end

        S_RUN: begin
          // The cycle in which the PC sits at the end address is not counted
          // as an executed core cycle; a timeout cycle is.
          if (core_pc == end_pc) begin
            state      <= S_DONE;
            status     <= ST_PASS_END;
            done       <= 1'b1;
            busy       <= 1'b0;
            core_reset <= 1'b1;
            halt_pc    <= core_pc;
          end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);
            if (budget_hit) begin
              state      <= S_DONE;
              status     <= ST_TIMEOUT;
              done       <= 1'b1;
              busy       <= 1'b0;
              core_reset <= 1'b1;
              halt_pc    <= core_pc;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: a behavioural core/memory stub plus
// a reference model of the load-and-run outcome.
module tb_mips_prog_loader;

  localparam int AW   = 8;
  localparam int CW   = 16;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-2:0] prog_len = '0;
  logic [CW-1:0] run_cycles = '0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;
  logic          core_reset;
  logic [31:0]   core_pc = '0;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [CW-1:0] cycle_count;
  logic [31:0]   halt_pc;

  always #5 clk = ~clk;

  mips_prog_loader #(.IMEM_ADDR_W(AW), .CYC_W(CW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
    .run_cycles(run_cycles), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .core_pc(core_pc),
    .busy(busy), .done(done), .status(status), .cycle_count(cycle_count),
    .halt_pc(halt_pc)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mem [0:255];
  logic [31:0] prog [0:127];
  int          wr_addr_q[$];
  int          wr_data_q[$];
  int          accepts = 0;
  int          cr_viol = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Core stub: always-taken beq, everything else falls through.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] off;
    off = {{14{ins[15]}}, ins[15:0], 2'b00};
    if (ins[31:26] == 6'h04) return pc + 32'd4 + off;
    return pc + 32'd4;
  endfunction

  // Instruction memory and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(int'(imem_wdata));
      mem[imem_addr] = imem_wdata;
    end
    if ((imem_we === 1'b1 || s_ready === 1'b1) && core_reset !== 1'b1) cr_viol++;
    if (s_valid === 1'b1 && s_ready === 1'b1) accepts++;
  end

  logic [31:0] fetched;
  logic [7:0]  pa;
  always @(posedge clk) begin
    if (core_reset !== 1'b0) core_pc <= '0;
    else begin
      pa      = core_pc[7:0];
      fetched = {mem[pa], mem[pa + 8'd1], mem[pa + 8'd2], mem[pa + 8'd3]};
      core_pc <= next_pc(core_pc, fetched);
    end
  end

  // Reference outcome from the program image and the run rules.
  function automatic void model_run(input int len, input int run, output int st,
                                    output int cnt, output logic [31:0] halt);
    logic [31:0] pc;
    pc = '0; cnt = 0; st = 0; halt = '0;
    if (len == 0 || BASE + 4 * len > (1 << AW)) begin st = 3; return; end
    for (int k = 0; k < 200000; k++) begin
      if (pc == 32'(BASE + 4 * len)) begin st = 1; halt = pc; return; end
      if (cnt < (1 << CW) - 1) cnt++;
      if (run != 0 && cnt == run) begin st = 2; halt = pc; return; end
      pc = next_pc(pc, prog[int'((pc - 32'(BASE)) >> 2) & 127]);
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h04) w[31:26] = 6'h00;
    return w;
  endfunction

  task automatic start_seq(input int len, input int run);
    wr_addr_q.delete();
    wr_data_q.delete();
    accepts    = 0;
    cr_viol    = 0;
    start      = 1'b1;
    prog_len   = 7'(len);
    run_cycles = 16'(run);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit poke_start);
    int n;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      if (poke_start) begin start = 1'($urandom); prog_len = 7'($urandom); end
      @(negedge clk);
    end
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (s_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) check("handshake_timeout", s_ready, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check("done_reached", done, 1'b1);
  endtask

  task automatic finish_check(input string tag, input int len, input int run);
    int st, cnt, nexp;
    logic [31:0] halt;
    model_run(len, run, st, cnt, halt);
    wait_done(3000);
    check({tag, "_status"}, status, st);
    check({tag, "_cycles"}, cycle_count, cnt);
    check({tag, "_halt_pc"}, halt_pc, halt);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
    nexp = (st == 3) ? 0 : 4 * len;
    check({tag, "_n_writes"}, wr_addr_q.size(), nexp);
    for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_wr_addr[%0d]", tag, i), wr_addr_q[i], (BASE + i) % (1 << AW));
      check($sformatf("%s_wr_data[%0d]", tag, i), wr_data_q[i],
            (prog[i / 4] >> (24 - 8 * (i % 4))) & 32'hFF);
    end
    check({tag, "_accepts"}, accepts, (st == 3) ? 0 : len);
    check({tag, "_core_reset_during_load"}, cr_viol, 0);
  endtask

  task automatic len_err_check(input string tag, input int len);
    start_seq(len, 5);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_status"}, status, 2'd3);
    check({tag, "_halt_pc"}, halt_pc, 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
    repeat (3) @(negedge clk);
    check({tag, "_no_writes"}, wr_addr_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, len, run;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 128; i++) prog[i] = 32'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", imem_addr, 8'h00);
    check("rst_imem_wdata", imem_wdata, 8'h00);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'd0);
    check("rst_cycle_count", cycle_count, 16'd0);
    check("rst_halt_pc", halt_pc, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Five-word loop program: beq never reaches the end, so it times out.
    prog[0] = 32'h02328020; prog[1] = 32'h0213A022; prog[2] = 32'hAE340020;
    prog[3] = 32'h8E280020; prog[4] = 32'h1288FFFB;
    start_seq(5, 20);
    check("prog5_busy_in_load", busy, 1'b1);
    check("prog5_s_ready_in_load", s_ready, 1'b1);
    for (int i = 0; i < 5; i++) send_word(prog[i], 0, 1'b0);
    finish_check("prog5", 5, 20);
    check("prog5_timeout_literal", status, 2'd2);
    check("prog5_count_literal", cycle_count, 16'd20);

    // Two words, unlimited budget: reaches the end address.
    prog[0] = 32'h02328020; prog[1] = 32'h0213A022;
    start_seq(2, 0);
    for (int i = 0; i < 2; i++) send_word(prog[i], 0, 1'b0);
    finish_check("prog2", 2, 0);
    check("prog2_halt_literal", halt_pc, 32'h8);

    // Length errors and the largest length that fits.
    len_err_check("len0", 0);
    len_err_check("len65", 65);
    len_err_check("len127", 127);
    for (int i = 0; i < 64; i++) prog[i] = rand_word();
    start_seq(64, 0);
    for (int i = 0; i < 64; i++) send_word(prog[i], 0, 1'b0);
    finish_check("len64", 64, 0);

    // Idle gaps and s_valid held through WRITE with a word that must be ignored.
    for (int i = 0; i < 3; i++) prog[i] = rand_word();
    start_seq(3, 0);
    send_word(prog[0], 0, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      check("write_s_ready_low", s_ready, 1'b0);
      check("write_we_high", imem_we, 1'b1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("gap_s_ready_high", s_ready, 1'b1);
      check("gap_no_write", imem_we, 1'b0);
      @(negedge clk);
    end
    send_word(prog[1], 0, 1'b0);
    send_word(prog[2], 3, 1'b0);
    finish_check("gaps", 3, 0);

    // Reset during the third byte of word 1, then a fresh load from BASE.
    for (int i = 0; i < 3; i++) prog[i] = rand_word();
    start_seq(3, 0);
    send_word(prog[0], 0, 1'b0);
    send_word(prog[1], 0, 1'b0);
    n = 0;
    while (!(imem_we === 1'b1 && imem_addr == 8'(BASE + 6)) && n < 20) begin
      @(negedge clk); n++;
    end
    check("midreset_reached_byte2", imem_addr, 8'(BASE + 6));
    reset = 1'b1;
    @(negedge clk);
    check("midreset_imem_we", imem_we, 1'b0);
    check("midreset_core_reset", core_reset, 1'b1);
    check("midreset_busy", busy, 1'b0);
    check("midreset_s_ready", s_ready, 1'b0);
    check("midreset_done", done, 1'b0);
    reset = 1'b0;
    prog[0] = rand_word();
    start_seq(1, 0);
    send_word(prog[0], 0, 1'b0);
    finish_check("after_reset", 1, 0);

    // Randomized programs, gaps, budgets and ignored start pulses while busy.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 12);
      run = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      for (int i = 0; i < len; i++) prog[i] = rand_word();
      start_seq(len, run);
      for (int i = 0; i < len; i++) send_word(prog[i], $urandom_range(0, 3), 1'b1);
      finish_check($sformatf("rand%0d", t), len, run);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
